// File: rtl/fmv_ddr_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : fmv_ddr_fetch_arbiter
// Brief   : Round-robin DDR burst fetcher feeding two byte-stream FIFOs.
// Revision: 1.0 - initial release
// ============================================================================
module fmv_ddr_fetch_arbiter #(
  parameter int BURST  = 4,
  parameter int ADDR_W = 28,
  parameter int LEN_W  = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic [1:0]            cfg_load_i,
  input  logic [2*ADDR_W-1:0]   cfg_addr_i,
  input  logic [2*LEN_W-1:0]    cfg_words_i,
  input  logic [1:0]            half_empty_i,
  output logic [1:0]            active_o,
  output logic [1:0]            done_o,
  output logic [ADDR_W-1:0]     ddr_addr_o,
  output logic [7:0]            ddr_burstcnt_o,
  output logic                  ddr_rd_o,
  input  logic                  ddr_busy_i,
  input  logic [63:0]           ddr_dout_i,
  input  logic                  ddr_dout_ready_i,
  output logic [1:0]            fifo_we_o,
  output logic [63:0]           fifo_wdata_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DATA = 2'd2
  } state_e;

  localparam logic [LEN_W-1:0] C_BURST_LEN = LEN_W'(BURST);

  state_e                   state_q, state_d;
  logic                     grant_q, grant_d;
  logic                     last_grant_q, last_grant_d;
  logic                     final_q, final_d;
  logic [1:0][ADDR_W-1:0]   ptr_q, ptr_d;
  logic [1:0][LEN_W-1:0]    rem_q, rem_d;
  logic [7:0]               beats_q, beats_d;
  logic                     rd_q, rd_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [7:0]               burstcnt_q, burstcnt_d;
  logic [1:0]               fifo_we_q, fifo_we_d;
  logic [63:0]              wdata_q, wdata_d;
  logic [1:0]               done_q, done_d;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q      <= S_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      final_q      <= 1'b0;
      ptr_q        <= '0;
      rem_q        <= '0;
      beats_q      <= '0;
      rd_q         <= 1'b0;
      addr_q       <= '0;
      burstcnt_q   <= '0;
      fifo_we_q    <= '0;
      wdata_q      <= '0;
      done_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      final_q      <= final_d;
      ptr_q        <= ptr_d;
      rem_q        <= rem_d;
      beats_q      <= beats_d;
      rd_q         <= rd_d;
      addr_q       <= addr_d;
      burstcnt_q   <= burstcnt_d;
      fifo_we_q    <= fifo_we_d;
      wdata_q      <= wdata_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    logic [1:0]       elig;
    logic             gnt;
    logic [LEN_W-1:0] rem_g;
    logic [LEN_W-1:0] bc_len;

    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    final_d      = final_q;
    ptr_d        = ptr_q;
    rem_d        = rem_q;
    beats_d      = beats_q;
    rd_d         = rd_q;
    addr_d       = addr_q;
    burstcnt_d   = burstcnt_q;
    fifo_we_d    = '0;
    wdata_d      = wdata_q;
    done_d       = '0;
    gnt          = 1'b0;
    rem_g        = '0;
    bc_len       = LEN_W'(burstcnt_q);

    for (int i = 0; i < 2; i++) begin
      elig[i] = (rem_q[i] != '0) && half_empty_i[i] && !cfg_load_i[i];
    end

    case (state_q)
      S_IDLE: begin
        if (|elig) begin
          gnt        = (elig == 2'b11) ? !last_grant_q : elig[1];
          rem_g      = rem_q[gnt];
          grant_d    = gnt;
          rd_d       = 1'b1;
          addr_d     = ptr_q[gnt];
          burstcnt_d = (rem_g > C_BURST_LEN) ? 8'(BURST) : 8'(rem_g);
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        if (!ddr_busy_i) begin
          rd_d            = 1'b0;
          ptr_d[grant_q]  = ptr_q[grant_q] + ADDR_W'(burstcnt_q);
          rem_d[grant_q]  = rem_q[grant_q] - bc_len;
          last_grant_d    = grant_q;
          final_d         = (rem_q[grant_q] == bc_len);
          beats_d         = burstcnt_q;
          state_d         = S_DATA;
          // Zero-latency DDR: the first beat can ride along with acceptance.
          if (ddr_dout_ready_i) begin
            fifo_we_d[grant_q] = 1'b1;
            wdata_d            = ddr_dout_i;
            beats_d            = burstcnt_q - 8'd1;
            if (burstcnt_q == 8'd1) begin
              state_d         = S_IDLE;
              done_d[grant_q] = final_d;
            end
          end
        end
      end
      S_DATA: begin
        if (ddr_dout_ready_i) begin
          fifo_we_d[grant_q] = 1'b1;
          wdata_d            = ddr_dout_i;
          beats_d            = beats_q - 8'd1;
          if (beats_q == 8'd1) begin
            state_d         = S_IDLE;
            done_d[grant_q] = final_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A reload wins over any in-flight bookkeeping and cancels the old run's done.
    for (int i = 0; i < 2; i++) begin
      if (cfg_load_i[i]) begin
        ptr_d[i]  = cfg_addr_i[i*ADDR_W +: ADDR_W];
        rem_d[i]  = cfg_words_i[i*LEN_W +: LEN_W];
        done_d[i] = (cfg_words_i[i*LEN_W +: LEN_W] == '0);
        if (grant_q == i[0]) begin
          final_d = 1'b0;
        end
      end
    end
  end

  assign active_o[0]    = (rem_q[0] != '0) || ((state_q != S_IDLE) && !grant_q);
  assign active_o[1]    = (rem_q[1] != '0) || ((state_q != S_IDLE) && grant_q);
  assign done_o         = done_q;
  assign ddr_addr_o     = addr_q;
  assign ddr_burstcnt_o = burstcnt_q;
  assign ddr_rd_o       = rd_q;
  assign fifo_we_o      = fifo_we_q;
  assign fifo_wdata_o   = wdata_q;

endmodule
`default_nettype wire

// File: doc/fmv_ddr_fetch_arbiter.md
Name: fmv_ddr_fetch_arbiter

Overview:
- Sequences DDR burst reads that feed two 64-bit-in / byte-out stream FIFOs (channel 0 = MPEG video, channel 1 = MPEG audio).
- Each channel is programmed with a start word address and a length, then refilled in bursts whenever its FIFO reports half_empty.
- Round-robin arbitration between the two channels for the single DDR read port.
- Returned DDR beats are routed to the granted channel's FIFO write port.

Parameters:
- BURST, 4, maximum 64-bit words per DDR read burst; power of two, 1..16.
- ADDR_W, 28, width of the DDR 64-bit word address.
- LEN_W, 16, width of the per-channel word-count register.

Ports:
- clk  input  1  single system clock; all logic on its rising edge.
- reset_n  input  1  synchronous, active-low reset.
- cfg_load  input  2  per-channel one-cycle pulse: load cfg_addr/cfg_words for that channel.
- cfg_addr  input  2*ADDR_W  start word address; [ADDR_W-1:0] = ch0, upper slice = ch1.
- cfg_words  input  2*LEN_W  number of 64-bit words to fetch; slices as cfg_addr.
- half_empty  input  2  per-channel FIFO has room for at least one burst.
- active  output  2  channel has words remaining or a burst in flight.
- done  output  2  one-cycle pulse: the last word of the channel's run has been written to its FIFO.
- ddr_addr  output  ADDR_W  burst start word address.
- ddr_burstcnt  output  8  burst length in words.
- ddr_rd  output  1  read request; held until accepted.
- ddr_busy  input  1  DDR waitrequest; request accepted on a cycle with ddr_rd=1 and ddr_busy=0.
- ddr_dout  input  64  read data beat.
- ddr_dout_ready  input  1  ddr_dout is valid this cycle.
- fifo_we  output  2  per-channel FIFO write strobe.
- fifo_wdata  output  64  shared FIFO write data.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - State goes to IDLE.
  - active, done, ddr_rd, fifo_we = 0; ddr_addr, ddr_burstcnt, fifo_wdata = 0.
  - Remaining counts = 0; last_grant = 1, so ch0 wins the first tie.
- Per-channel registers: ptr (ADDR_W), remaining (LEN_W).
- Loading (cfg_load[i]=1):
  - ptr <= cfg_addr slice and remaining <= cfg_words slice, effective next cycle.
  - A load overrides a same-cycle decrement or increment.
- Eligibility: eligible[i] = (remaining[i] != 0) && half_empty[i] && no cfg_load[i] this cycle.
- States:
  - IDLE:
    - If any channel is eligible: grant = the eligible channel; if both are eligible, grant = !last_grant.
    - Drive ddr_rd=1, ddr_addr=ptr[grant], ddr_burstcnt = min(BURST, remaining[grant]) (registered, asserted next cycle). Go to REQ.
  - REQ:
    - Hold ddr_rd, ddr_addr, ddr_burstcnt stable while ddr_busy=1.
    - On acceptance: ddr_rd <= 0; ptr[grant] += burstcnt; remaining[grant] -= burstcnt; beat counter <= burstcnt; last_grant <= grant. Go to DATA.
  - DATA:
    - Each ddr_dout_ready: fifo_wdata <= ddr_dout and fifo_we[grant] <= 1, both registered with 1-cycle latency; beat counter decrements.
    - On the final beat, go to IDLE. A new request may issue the cycle after the last beat.
    - Minimum gap between consecutive bursts is therefore 1 idle cycle.
    - A beat arriving in the same cycle the request is accepted (zero-latency DDR) is also captured.
- ddr_dout_ready outside DATA is ignored: no fifo_we.
- done[i]:
  - Pulses together with the fifo_we of the final beat when remaining[i] became 0 at that burst's acceptance and no reload has occurred since.
  - cfg_load with cfg_words=0 pulses done[i] the following cycle and issues no requests.
- active[i] = (remaining[i] != 0) || (state != IDLE && grant == i).
- cfg_load on the granted channel during REQ/DATA:
  - The in-flight burst completes and its data is still written.
  - The new ptr/remaining take effect as loaded, with no done pulse for the aborted run.
- half_empty is sampled only in IDLE. Deassertion after grant does not cancel the burst.
- ptr wraps modulo 2^ADDR_W. Widths: burstcnt is zero-extended to LEN_W/ADDR_W for arithmetic.
- Reset mid-burst: abandon the burst; stray beats are ignored. Downstream FIFOs are reset by the owner.

Test Plan:
- Reset, load ch0 addr=0x100 words=10, half_empty=2'b01, 2-cycle ddr_busy per request → bursts (0x100,4), (0x104,4), (0x108,2); 10 fifo_we[0] with data in order; done[0] with 10th write.
- Both channels loaded words=8, half_empty=2'b11 → grants alternate ch0, ch1, ch0, ch1; each fifo_we bit fires 8 times; no cross-routing.
- ch0 words=8, half_empty[0] low after first burst → only one burst (4 words) until half_empty rises again; active[0] stays 1.
- cfg_load ch1 words=0 → done[1] next cycle, ddr_rd never asserted.
- Reload ch0 (addr=0x200, words=4) during DATA of a ch0 burst → current 4 beats written, next burst at 0x200, exactly one done[0] after the reload's data.
- reset_n low during DATA, then 2 stray ddr_dout_ready beats → fifo_we stays 0, state IDLE, active=0.
